// File: rtl/wb_memtest_master_if.sv
// Pipelined Wishbone B4 bus bundle between the memory-test master and a slave.
// clk/rst ride along so both ends share the same clock and reset nets.
interface wb_if (
  input logic clk,
  input logic rst
);
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [31:0] dat_m;
  logic [31:0] dat_s;
  logic        ack;
  logic        stall;
  logic        err;

  modport master (
    input  clk, rst, ack, stall, err, dat_s,
    output cyc, stb, we, sel, adr, dat_m
  );

  modport slave (
    input  clk, rst, cyc, stb, we, sel, adr, dat_m,
    output ack, stall, err, dat_s
  );
endinterface

// File: rtl/wb_memtest_master.sv
// Wishbone memory tester: writes seed^address to a block of words, then
// reads it back with pipelined requests and reports pass/fail/bus error.
module wb_memtest_master #(
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned COUNT_WIDTH     = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [31:0]            base_adr,
  input  logic [COUNT_WIDTH-1:0] count,
  input  logic [31:0]            seed,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic                   bus_err,
  output logic [31:0]            fail_adr,
  wb_if.master                   wb
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_WDRAIN,
    S_READ,
    S_RDRAIN,
    S_FINISH
  } state_t;

  localparam logic [3:0] MAX_O = 4'(MAX_OUTSTANDING);

  state_t                 state_q, state_d;
  logic [31:0]            base_q, base_d;
  logic [31:0]            seed_q, seed_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [COUNT_WIDTH-1:0] iss_q, iss_d;
  logic [COUNT_WIDTH-1:0] aidx_q, aidx_d;
  logic [3:0]             outst_q, outst_d;
  logic                   cyc_q, cyc_d;
  logic                   stb_q, stb_d;
  logic                   we_q, we_d;
  logic [31:0]            adr_q, adr_d;
  logic [31:0]            dat_q, dat_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   pass_q, pass_d;
  logic                   berr_q, berr_d;
  logic [31:0]            fail_q, fail_d;
  logic                   miss_q, miss_d;

  logic        accept;
  logic        ack_in;
  logic        err_in;
  logic        bad;
  logic [31:0] ack_adr;

  always_comb begin
    accept  = stb_q & ~wb.stall;
    ack_in  = cyc_q & wb.ack;
    err_in  = cyc_q & wb.err;
    ack_adr = base_q + (32'(aidx_q) << 2);
    bad     = ack_in & ~we_q & (wb.dat_s != (seed_q ^ ack_adr));

    state_d = state_q;
    base_d  = base_q;
    seed_d  = seed_q;
    cnt_d   = cnt_q;
    iss_d   = iss_q + COUNT_WIDTH'(accept);
    aidx_d  = aidx_q + COUNT_WIDTH'(ack_in);
    cyc_d   = cyc_q;
    stb_d   = stb_q;
    we_d    = we_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    berr_d  = berr_q;
    fail_d  = fail_q;
    miss_d  = miss_q;

    outst_d = outst_q;
    if (accept & ~ack_in) begin
      outst_d = outst_q + 4'd1;
    end else if (~accept & ack_in & (outst_q != 4'd0)) begin
      outst_d = outst_q - 4'd1;
    end

    // only the first miscompare is reported
    if (bad & ~miss_q) begin
      miss_d = 1'b1;
      fail_d = ack_adr;
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d  = {base_adr[31:2], 2'b00};
          seed_d  = seed;
          cnt_d   = count;
          iss_d   = '0;
          aidx_d  = '0;
          outst_d = 4'd0;
          busy_d  = 1'b1;
          pass_d  = 1'b0;
          berr_d  = 1'b0;
          fail_d  = 32'd0;
          miss_d  = 1'b0;
          if (count == '0) begin
            state_d = S_FINISH;
            done_d  = 1'b1;
            pass_d  = 1'b1;
          end else begin
            state_d = S_WRITE;
            cyc_d   = 1'b1;
            stb_d   = 1'b1;
            we_d    = 1'b1;
          end
        end
      end
      S_WRITE, S_READ: begin
        if (iss_d == cnt_q) begin
          stb_d   = 1'b0;
          state_d = (state_q == S_WRITE) ? S_WDRAIN : S_RDRAIN;
        end else begin
          stb_d = (outst_d < MAX_O);
        end
      end
      S_WDRAIN: begin
        if (outst_d == 4'd0) begin
          state_d = S_READ;
          iss_d   = '0;
          aidx_d  = '0;
          we_d    = 1'b0;
          stb_d   = 1'b1;
        end
      end
      S_RDRAIN: begin
        if (outst_d == 4'd0) begin
          state_d = S_FINISH;
          cyc_d   = 1'b0;
          done_d  = 1'b1;
          pass_d  = ~miss_d;
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase

    // a bus error aborts the test from any active state
    if (err_in) begin
      state_d = S_FINISH;
      cyc_d   = 1'b0;
      stb_d   = 1'b0;
      berr_d  = 1'b1;
      done_d  = 1'b1;
      pass_d  = 1'b0;
      if (!miss_q) begin
        fail_d = ack_adr;
      end
    end

    adr_d = base_d + (32'(iss_d) << 2);
    dat_d = seed_d ^ adr_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      base_q  <= 32'd0;
      seed_q  <= 32'd0;
      cnt_q   <= '0;
      iss_q   <= '0;
      aidx_q  <= '0;
      outst_q <= 4'd0;
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= 32'd0;
      dat_q   <= 32'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      berr_q  <= 1'b0;
      fail_q  <= 32'd0;
      miss_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      seed_q  <= seed_d;
      cnt_q   <= cnt_d;
      iss_q   <= iss_d;
      aidx_q  <= aidx_d;
      outst_q <= outst_d;
      cyc_q   <= cyc_d;
      stb_q   <= stb_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      berr_q  <= berr_d;
      fail_q  <= fail_d;
      miss_q  <= miss_d;
    end
  end

  assign wb.cyc   = cyc_q;
  assign wb.stb   = stb_q;
  assign wb.we    = we_q;
  assign wb.sel   = 4'hF;
  assign wb.adr   = adr_q;
  assign wb.dat_m = dat_q;

  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign bus_err  = berr_q;
  assign fail_adr = fail_q;

endmodule

// File: doc/wb_memtest_master.md
WB_MEMTEST_MASTER -- requirements
Module: wb_memtest_master

Interface
REQ-001 Parameter MAX_OUTSTANDING, default 4: maximum issued-but-unacknowledged Wishbone requests, 1..15.
REQ-002 Parameter COUNT_WIDTH, default 16: width of the word-count input.
REQ-003 Port clk  input  1: sole clock; wb.clk SHALL be driven from the same net.
REQ-004 Port rst  input  1: reset, asynchronous, active-high; wb.rst SHALL be driven from the same net.
REQ-005 Port start  input  1: single-cycle pulse that begins a test; ignored unless idle.
REQ-006 Port base_adr  input  32: byte address of the first word; bits [1:0] ignored and treated as 0.
REQ-007 Port count  input  COUNT_WIDTH: number of 32-bit words to test.
REQ-008 Port seed  input  32: pattern seed.
REQ-009 Port busy  output  1: high while a test is in progress.
REQ-010 Port done  output  1: single-cycle pulse at test end.
REQ-011 Port pass  output  1: result of the last test, valid from done until the next start.
REQ-012 Port bus_err  output  1: last test was aborted by wb.err.
REQ-013 Port fail_adr  output  32: byte address of the first miscompare or error.
REQ-014 Port wb  wb_if.master: pipelined Wishbone B4 master port; drives cyc, stb, we, sel, adr, dat_m; samples ack, stall, err, dat_s.

Function
REQ-015 base_adr, count and seed SHALL be captured on an accepted start; later input changes have no effect.
REQ-016 Pattern for word i SHALL be seed XOR (base_adr + 4*i), with 32-bit wrap-around addition.
REQ-017 States: IDLE, WRITE, WDRAIN, READ, RDRAIN, FINISH.
REQ-018 IDLE + start: if count=0, go to FINISH with pass=1; otherwise go to WRITE.
REQ-019 WRITE: stb=1, we=1, sel=4'hF, adr=base+4*issue_idx, dat_m=pattern; a request is accepted when stb & ~stall.
REQ-020 stb SHALL be deasserted when outstanding = MAX_OUTSTANDING; stb, adr and dat_m SHALL hold while stalled.
REQ-021 The outstanding counter SHALL increment on acceptance and decrement on ack; simultaneous accept and ack leave it unchanged.
REQ-022 After count writes are accepted: go to WDRAIN (stb=0, cyc=1) until outstanding=0, then go to READ with the issue index cleared.
REQ-023 READ/RDRAIN mirror WRITE/WDRAIN with we=0; acks return in order and the ack-index counter selects the expected pattern.
REQ-024 On read ack with dat_s != expected: record fail_adr for the first miscompare only; pass is later cleared; the read sequence continues to completion.
REQ-025 wb.err on any cycle with cyc=1: set bus_err, record fail_adr (acked-word address), drop cyc and stb the next cycle, go to FINISH; later acks are ignored.
REQ-026 cyc SHALL be high from the first WRITE cycle through the last ack of RDRAIN, and low otherwise.
REQ-027 FINISH lasts one cycle: done=1, busy=0 the next cycle, return to IDLE.
REQ-028 busy SHALL be high in every state except IDLE; start while busy is ignored.
REQ-029 At most one request is issued per cycle; with stall=0 and acks arriving one cycle later, throughput is one word per cycle.
REQ-030 Total latency with zero stall and 1-cycle ack: start to done = 2*count + 4 cycles, ±1.

Reset
REQ-031 Asynchronous rst SHALL force IDLE and set cyc, stb, we, busy, done, bus_err, pass and fail_adr to 0, and the counters to 0, immediately.
REQ-032 rst asserted mid-transfer SHALL abandon outstanding requests; acks arriving after reset release are ignored.

Verification
REQ-033 Zero-wait RAM slave, base=0x100, count=8, seed=0xA5A5A5A5 -> 8 writes then 8 reads, pass=1, bus_err=0, done within 20 cycles.
REQ-034 Same setup; slave corrupts the word at 0x10C on read -> pass=0, fail_adr=0x10C, all 8 reads still issued.
REQ-035 Random stall (50%), ack delay 1-3 cycles, MAX_OUTSTANDING=4, count=64 -> outstanding never exceeds 4, adr/dat_m held while stalled, pass=1.
REQ-036 wb.err on the 3rd write ack, base=0 -> bus_err=1, fail_adr=0x8, cyc low the next cycle, done pulses, pass=0.
REQ-037 count=0 -> done one cycle after start, pass=1, cyc never asserted.
REQ-038 rst pulsed during READ with 3 requests outstanding -> all outputs 0 immediately; a new start then completes a full test with pass=1.
